// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared LC-3b fetch types, constants and alignment helper
package fetch_unit_pkg;
  typedef logic [15:0] lc3b_word;
  localparam lc3b_word LC3B_INSTR_BYTES = 16'd2;
  typedef enum logic {FETCH, HOLD} fetch_state_t;
  typedef enum logic [1:0] {PC_INC, PC_TGT, PC_PEND} pc_sel_t;
  function automatic lc3b_word align(input lc3b_word a);
    return a & 16'hFFFE;
  endfunction
endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter with sequential / redirect / pending-redirect select, always halfword aligned
module fetch_pc import fetch_unit_pkg::*; #(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     ld,
  input  pc_sel_t  sel,
  input  lc3b_word target,
  input  lc3b_word pend_pc,
  output lc3b_word pc
);
  lc3b_word nxt_pc;
  // choose the next fetch address; pc+2 wraps modulo 2^16
  always_comb nxt_pc = sel == PC_TGT ? target : sel == PC_PEND ? pend_pc : pc + LC3B_INSTR_BYTES;
  // pc register, bit 0 cleared on every load
  always_ff @(posedge clk)
    if (reset) pc <= align(RESET_PC);
    else if (ld) pc <= align(nxt_pc);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: LC-3b fetch stage; optional HOLD stall counter under FETCH_STALL_CNT_EN
module fetch_unit import fetch_unit_pkg::*; #(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     reset,
  output logic     mem_read,
  output lc3b_word mem_address,
  input  logic     mem_resp,
  input  lc3b_word mem_rdata,
  input  logic     decode_ready,
  output logic     instr_valid,
  output logic     ir_load,
  output lc3b_word instr,
  output lc3b_word instr_pc,
  output lc3b_word pc_plus2,
  input  logic     redirect,
  input  lc3b_word redirect_target
`ifdef FETCH_STALL_CNT_EN
  ,
  output lc3b_word stall_count
`endif
);
  fetch_state_t state, state_nxt;
  pc_sel_t pc_sel;
  logic armed, pend, resp, take, pc_ld;
  lc3b_word pc, pend_pc, tgt;
  // armed is low for the first cycle after reset so a response to a read abandoned by reset is ignored
  assign resp = mem_resp & armed & (state == FETCH);
  assign take = resp & ~pend & ~redirect;
  assign tgt = align(redirect_target);
  assign mem_address = pc;
  assign pc_plus2 = instr_pc + LC3B_INSTR_BYTES;
  fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .ld(pc_ld), .sel(pc_sel),
    .target(tgt), .pend_pc(pend_pc), .pc(pc)
  );
  // state register
  always_ff @(posedge clk)
    if (reset) state <= FETCH;
    else state <= state_nxt;
  // next state: a redirect or consume leaves HOLD; only an accepted response enters it
  always_comb
    state_nxt = state == HOLD ? ((redirect | decode_ready) ? FETCH : HOLD) : (take ? HOLD : FETCH);
  // outputs and pc control; redirect outranks everything else
  always_comb begin
    mem_read = ~reset & (state == FETCH);
    instr_valid = ~reset & (state == HOLD);
    ir_load = instr_valid & decode_ready & ~redirect;
    pc_ld = redirect ? (state == HOLD) | resp : resp;
    pc_sel = redirect ? PC_TGT : pend ? PC_PEND : PC_INC;
  end
  // captured instruction plus the deferred-redirect bookkeeping for reads that must run to completion
  always_ff @(posedge clk) begin
    armed <= ~reset;
    if (reset) begin
      pend <= 1'b0;
      instr <= '0;
      instr_pc <= '0;
    end else begin
      if (take) begin
        instr <= mem_rdata;
        instr_pc <= pc;
      end
      if (resp) pend <= 1'b0;
      else if (redirect && state == FETCH) begin
        pend <= 1'b1;
        pend_pc <= tgt;
      end
    end
  end
`ifdef FETCH_STALL_CNT_EN
  // saturating count of cycles an instruction waits on decode
  always_ff @(posedge clk)
    if (reset) stall_count <= '0;
    else if (instr_valid && !decode_ready && !redirect && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven and random checks of fetch_unit against a memory model and scoreboard
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  localparam lc3b_word RST_PC = 16'h0000;
  logic clk = 0, reset = 1, mem_resp = 0, decode_ready = 1, redirect = 0;
  lc3b_word mem_rdata = 0, redirect_target = 0;
  logic mem_read, instr_valid, ir_load;
  lc3b_word mem_address, instr, instr_pc, pc_plus2;
`ifdef FETCH_STALL_CNT_EN
  lc3b_word stall_count;
`endif
  int n_chk = 0, n_fail = 0, lat = 3, cnt = 0, idle = 0;
  logic late = 0;
  lc3b_word maddr = 0, mp = 0;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_address(mem_address),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .decode_ready(decode_ready),
    .instr_valid(instr_valid), .ir_load(ir_load), .instr(instr), .instr_pc(instr_pc),
    .pc_plus2(pc_plus2), .redirect(redirect), .redirect_target(redirect_target)
`ifdef FETCH_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic lc3b_word word_at(input lc3b_word a);
    return a == 16'h0006 ? 16'h1261 : (a ^ 16'hC35A) + {a[7:0], a[15:8]};
  endfunction

  task automatic chk(input string nm, input lc3b_word act, input lc3b_word exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid();
    #1;
    for (int i = 0; i < 40 && !instr_valid; i++) cyc();
    chk1("wait_valid", instr_valid, 1'b1);
  endtask

  task automatic wait_load();
    #1;
    for (int i = 0; i < 40 && !ir_load; i++) cyc();
    chk1("wait_ir_load", ir_load, 1'b1);
  endtask

  task automatic wait_resp();
    #1;
    for (int i = 0; i < 40 && !mem_resp; i++) cyc();
    chk1("wait_mem_resp", mem_resp, 1'b1);
  endtask

  // memory: answers after lat counted request cycles with the word of the captured address
  always @(posedge clk) begin
    #1;
    if (reset) begin
      cnt = 0;
      mem_resp = late;
      mem_rdata = 16'hDEAD;
    end else begin
      if (mem_resp) begin
        mem_resp = 0;
        cnt = 0;
      end
      if (mem_read) begin
        cnt++;
        if (cnt == 1) maddr = mem_address;
        else chk("addr_stable", mem_address, maddr);
        if (cnt >= lat) begin
          mem_resp = 1;
          mem_rdata = word_at(maddr);
        end
      end
    end
  end

  // scoreboard: expected program-order stream of delivered instructions
  always @(negedge clk) begin
    if (reset) begin
      chk1("rst_mem_read", mem_read, 1'b0);
      chk1("rst_instr_valid", instr_valid, 1'b0);
      chk1("rst_ir_load", ir_load, 1'b0);
      mp = RST_PC;
      idle = 0;
    end else begin
      chk1("ir_load", ir_load, instr_valid & decode_ready & ~redirect);
      if (instr_valid) begin
        chk("instr_pc", instr_pc, mp);
        chk("instr", instr, word_at(mp));
        chk("pc_plus2", pc_plus2, mp + 16'd2);
      end
      if (redirect) mp = redirect_target & 16'hFFFE;
      else if (ir_load) mp = mp + 16'd2;
      idle = ir_load ? 0 : idle + 1;
      chk1("progress", idle > 100, 1'b0);
      if (idle > 100) idle = 0;
    end
  end

  typedef struct {lc3b_word tgt, addr, plus2, nxt;} vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{16'h3001, 16'h3000, 16'h3002, 16'h3002};
    tbl[1] = '{16'hFFFE, 16'hFFFE, 16'h0000, 16'h0000};
    tbl[2] = '{16'hFFFF, 16'hFFFE, 16'h0000, 16'h0000};
    tbl[3] = '{16'h0000, 16'h0000, 16'h0002, 16'h0002};
    tbl[4] = '{16'h7FFD, 16'h7FFC, 16'h7FFE, 16'h7FFE};
    repeat (3) cyc();
    reset = 0;
    #1;
    chk1("first_req", mem_read, 1'b1);
    chk("first_addr", mem_address, RST_PC);
    for (int k = 0; k < 3; k++) begin
      wait_load();
      chk("seq_pc", instr_pc, RST_PC + 16'(2 * k));
      cyc();
      chk1("ir_load_pulse", ir_load, 1'b0);
      chk("seq_next_addr", mem_address, RST_PC + 16'(2 * k + 2));
    end
    decode_ready = 0;
    wait_valid();
    chk("stall_instr_first", instr, 16'h1261);
    for (int i = 0; i < 5; i++) begin
      chk("stall_instr", instr, 16'h1261);
      chk1("stall_mem_read", mem_read, 1'b0);
      chk1("stall_valid", instr_valid, 1'b1);
      cyc();
    end
`ifdef FETCH_STALL_CNT_EN
    chk("stall_count", stall_count, 16'd5);
`endif
    decode_ready = 1;
    #1;
    chk1("stall_release", ir_load, 1'b1);
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    wait_load();
    cyc();
    wait_load();
    cyc();
    chk("read4_addr", mem_address, 16'h0004);
    cyc();
    redirect = 1;
    redirect_target = 16'h3000;
    cyc();
    redirect = 0;
    #1;
    for (int i = 0; i < 10 && !mem_resp; i++) begin
      chk("inflight_addr", mem_address, 16'h0004);
      chk1("inflight_valid", instr_valid, 1'b0);
      cyc();
    end
    chk1("inflight_resp", mem_resp, 1'b1);
    chk("inflight_resp_addr", mem_address, 16'h0004);
    cyc();
    chk("pend_redir_addr", mem_address, 16'h3000);
    chk1("pend_redir_read", mem_read, 1'b1);
    chk1("pend_redir_valid", instr_valid, 1'b0);
    wait_load();
    chk("pend_redir_pc", instr_pc, 16'h3000);
    cyc();
    wait_resp();
    redirect = 1;
    redirect_target = 16'h3001;
    cyc();
    redirect = 0;
    chk("coinc_addr", mem_address, 16'h3000);
    chk1("coinc_read", mem_read, 1'b1);
    chk1("coinc_valid", instr_valid, 1'b0);
    wait_load();
    chk("coinc_pc", instr_pc, 16'h3000);
    lat = 5;
    cyc();
    redirect = 1;
    redirect_target = 16'h4000;
    cyc();
    redirect_target = 16'h5000;
    cyc();
    redirect = 0;
    wait_resp();
    chk1("two_redir_valid", instr_valid, 1'b0);
    cyc();
    chk("two_redir_addr", mem_address, 16'h5000);
    wait_load();
    chk("two_redir_pc", instr_pc, 16'h5000);
    lat = 2;
    cyc();
    foreach (tbl[j]) begin
      decode_ready = 0;
      wait_valid();
      redirect = 1;
      redirect_target = tbl[j].tgt;
      #1;
      chk1("tbl_drop", ir_load, 1'b0);
      cyc();
      redirect = 0;
      chk("tbl_addr", mem_address, tbl[j].addr);
      wait_valid();
      chk("tbl_instr_pc", instr_pc, tbl[j].addr);
      chk("tbl_pc_plus2", pc_plus2, tbl[j].plus2);
      decode_ready = 1;
      cyc();
      chk("tbl_next_addr", mem_address, tbl[j].nxt);
    end
    lat = 3;
    cyc();
    chk1("mid_read_active", mem_read, 1'b1);
    late = 1;
    reset = 1;
    #1;
    chk1("mid_rst_read", mem_read, 1'b0);
    chk1("mid_rst_valid", instr_valid, 1'b0);
    cyc();
    reset = 0;
    late = 0;
    #1;
    chk1("post_rst_read", mem_read, 1'b1);
    chk("post_rst_addr", mem_address, RST_PC);
    cyc();
    chk1("late_resp_ignored", instr_valid, 1'b0);
    wait_load();
    chk("post_rst_pc", instr_pc, RST_PC);
    chk("post_rst_instr", instr, word_at(RST_PC));
    cyc();
    for (int i = 0; i < 600; i++) begin
      decode_ready = $urandom_range(0, 3) != 0;
      redirect = $urandom_range(0, 9) == 0;
      redirect_target = 16'($urandom);
      reset = $urandom_range(0, 199) == 0;
      if (!mem_read) lat = int'($urandom_range(1, 4));
      cyc();
    end
    reset = 0;
    redirect = 0;
    decode_ready = 1;
    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end
endmodule
